// File: rtl/uib_pkg.sv
// Shared types and constants for the UIB bus arbiter.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SLAVE_WIDTH
`define SLAVE_WIDTH 4
`endif

package uib_pkg;

  localparam int unsigned XLEN                = `XLEN;
  localparam int unsigned SLAVE_WIDTH         = `SLAVE_WIDTH;
  localparam int unsigned UIB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/uib_arbiter_rr_picker.sv
// Combinational rotate-priority select: first requester at or after ptr+1 (mod N).
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] grant,
  output logic          valid
);

  always_comb begin
    logic [GW-1:0] idx;
    idx   = '0;
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = GW'((32'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uib_arbiter.sv
// Round-robin arbiter: N upstream masters share one downstream bus port,
// one transfer at a time, with a per-transfer s_ready timeout.
module uib_arbiter
  import uib_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned TIMEOUT   = UIB_TIMEOUT_DEFAULT
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_MASTERS-1:0]                         m_req,
  input  logic [N_MASTERS-1:0]                         m_wen,
  input  logic [N_MASTERS-1:0][XLEN-SLAVE_WIDTH-1:0]   m_addr,
  input  logic [N_MASTERS-1:0][SLAVE_WIDTH-1:0]        m_num,
  input  logic [N_MASTERS-1:0][2:0]                    m_mode,
  input  logic [N_MASTERS-1:0][XLEN-1:0]               m_dat_o,
  output logic [XLEN-1:0]                              m_dat_i,
  output logic [N_MASTERS-1:0]                         m_ready,
  output logic                                         s_req,
  output logic                                         s_wen,
  output logic [XLEN-SLAVE_WIDTH-1:0]                  s_addr,
  output logic [SLAVE_WIDTH-1:0]                       s_num,
  output logic [2:0]                                   s_mode,
  output logic [XLEN-1:0]                              s_dat_o,
  input  logic [XLEN-1:0]                              s_dat_i,
  input  logic                                         s_ready,
  output logic [$clog2(N_MASTERS)-1:0]                 grant_id,
  output logic                                         busy,
  output logic                                         timeout_err
);

  localparam int unsigned GW      = $clog2(N_MASTERS);
  // Counter holds completed no-ready cycles, so the current cycle is the
  // TIMEOUT-th one when it reads TIMEOUT-1.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  arb_state_t    state, state_nxt;
  logic [GW-1:0] ptr_q;
  logic [15:0]   wait_cnt;
  logic [GW-1:0] pick_grant;
  logic          pick_valid;
  logic          s_hit, t_hit, done;

  rr_picker #(
    .N  (N_MASTERS),
    .GW (GW)
  ) u_pick (
    .req   (m_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign s_hit = (state == BUSY) && s_ready;
  assign t_hit = (state == BUSY) && !s_ready && (wait_cnt == TO_LAST);
  assign done  = s_hit || t_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = BUSY;
      BUSY:    if (done)       state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id    <= '0;
      ptr_q       <= GW'(N_MASTERS - 1);
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && pick_valid) begin
        grant_id <= pick_grant;
        wait_cnt <= '0;
      end
      if (state == BUSY) begin
        if (done) begin
          ptr_q    <= grant_id;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
        if (t_hit) timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    s_req   = 1'b0;
    s_wen   = 1'b0;
    s_addr  = '0;
    s_num   = '0;
    s_mode  = '0;
    s_dat_o = '0;
    m_ready = '0;
    m_dat_i = '0;
    busy    = (state != IDLE);
    if (state == BUSY) begin
      s_req   = 1'b1;
      s_wen   = m_wen[grant_id];
      s_addr  = m_addr[grant_id];
      s_num   = m_num[grant_id];
      s_mode  = m_mode[grant_id];
      s_dat_o = m_dat_o[grant_id];
      if (done) m_ready[grant_id] = 1'b1;
      if (s_hit) m_dat_i = s_dat_i;
    end
  end

endmodule

// File: tb/tb_uib_arbiter.sv
// Randomized scoreboard bench for uib_arbiter with a transaction-level model.
module tb_uib_arbiter;
  import uib_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 4;
  localparam int unsigned GW = $clog2(N);
  localparam int unsigned AW = XLEN - SLAVE_WIDTH;
  localparam int unsigned R  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]                    m_req, m_wen, m_ready;
  logic [N-1:0][AW-1:0]            m_addr;
  logic [N-1:0][SLAVE_WIDTH-1:0]   m_num;
  logic [N-1:0][2:0]               m_mode;
  logic [N-1:0][XLEN-1:0]          m_dat_o;
  logic [XLEN-1:0]                 m_dat_i, s_dat_o, s_dat_i;
  logic                            s_req, s_wen, s_ready, busy, timeout_err;
  logic [AW-1:0]                   s_addr;
  logic [SLAVE_WIDTH-1:0]          s_num;
  logic [2:0]                      s_mode;
  logic [GW-1:0]                   grant_id;

  uib_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr),
    .m_num(m_num), .m_mode(m_mode), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_ready(m_ready), .s_req(s_req), .s_wen(s_wen), .s_addr(s_addr),
    .s_num(s_num), .s_mode(s_mode), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ready(s_ready), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned     id;
    logic            wen;
    logic [AW-1:0]   addr;
    logic [SLAVE_WIDTH-1:0] num;
    logic [2:0]      mode;
    logic [XLEN-1:0] dat_o;
    logic [XLEN-1:0] dat_i;
    int unsigned     len;
    int unsigned     gap;
    logic            err;
  } exp_t;

  typedef struct {
    int unsigned     delay;
    logic [XLEN-1:0] data;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;

  logic                   pay_wen  [N][R];
  logic [AW-1:0]          pay_addr [N][R];
  logic [SLAVE_WIDTH-1:0] pay_num  [N][R];
  logic [2:0]             pay_mode [N][R];
  logic [XLEN-1:0]        pay_dat  [N][R];

  int unsigned model_ptr = N - 1;
  logic        model_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Slave model: asserts s_ready on the delay-th cycle of s_req for each transfer.
  initial begin
    int unsigned rcnt;
    rsp_t cur;
    rcnt    = 0;
    cur     = '{delay: 1000, data: '0};
    s_ready = 1'b0;
    s_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!s_req || !rst) begin
        rcnt    = 0;
        s_ready = 1'b0;
        s_dat_i = $urandom;
      end else begin
        if (rcnt == 0) begin
          if (rsp_q.size() > 0) cur = rsp_q.pop_front();
          else cur = '{delay: 1000, data: '0};
        end
        rcnt++;
        s_ready = (rcnt == cur.delay);
        s_dat_i = s_ready ? cur.data : $urandom;
      end
    end
  end

  // Monitor: pops one expectation per m_ready pulse.
  initial begin
    int unsigned ncyc, blen, last_rdy;
    logic        err_pend, err_exp;
    exp_t        e;
    ncyc = 0; blen = 0; last_rdy = 0; err_pend = 1'b0; err_exp = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst) begin
        blen     = 0;
        err_pend = 1'b0;
      end else begin
        if (err_pend) begin
          check("timeout_err_after", timeout_err, err_exp);
          check("release_busy", busy, 1);
          check("release_s_req", s_req, 0);
          err_pend = 1'b0;
        end
        if (s_req) blen++;
        if (m_ready != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_m_ready actual=%0h required=0", m_ready);
          end else begin
            e = exp_q.pop_front();
            check("m_ready", m_ready, 64'(1) << e.id);
            check("ready_in_busy", s_req, 1);
            check("grant_id", grant_id, e.id);
            check("s_wen", s_wen, e.wen);
            check("s_addr", s_addr, e.addr);
            check("s_num", s_num, e.num);
            check("s_mode", s_mode, e.mode);
            check("s_dat_o", s_dat_o, e.dat_o);
            check("m_dat_i", m_dat_i, e.dat_i);
            check("busy_len", blen, e.len);
            if (e.gap != 0) check("issue_gap", ncyc - last_rdy, e.gap);
            err_exp  = e.err;
            err_pend = 1'b1;
          end
          last_rdy = ncyc;
          blen     = 0;
        end else if (!s_req) begin
          check("idle_outputs_zero", 64'(|{m_dat_i, s_wen, s_addr, s_num, s_mode, s_dat_o}), 0);
        end
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int r = 0; r < R; r++) begin
        pay_wen[i][r]  = 1'($urandom);
        pay_addr[i][r] = AW'($urandom);
        pay_num[i][r]  = SLAVE_WIDTH'($urandom);
        pay_mode[i][r] = 3'($urandom);
        pay_dat[i][r]  = $urandom;
      end
  endtask

  task automatic drive(input logic [N-1:0] mask, input int unsigned reps, input int unsigned dn[N]);
    for (int i = 0; i < N; i++) begin
      int unsigned r;
      r = (dn[i] < reps) ? dn[i] : reps - 1;
      m_req[i]   = mask[i] && (dn[i] < reps);
      m_wen[i]   = pay_wen[i][r];
      m_addr[i]  = pay_addr[i][r];
      m_num[i]   = pay_num[i][r];
      m_mode[i]  = pay_mode[i][r];
      m_dat_o[i] = pay_dat[i][r];
    end
  endtask

  // Each master in mask issues reps transfers; delay 0 means random slave latency.
  task automatic run_round(input logic [N-1:0] mask, input int unsigned reps,
                           input int unsigned fdelay, input logic fdata_en,
                           input logic [XLEN-1:0] fdata);
    int unsigned rem[N];
    int unsigned dn[N];
    int unsigned total, w, d, rep, cyc;
    logic        first, to, all_done;
    rsp_t        rs;
    exp_t        e;
    total = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = mask[i] ? reps : 0;
      dn[i]  = 0;
      total += rem[i];
    end
    first = 1'b1;
    for (int unsigned t = 0; t < total; t++) begin
      w = 0;
      for (int unsigned k = N; k >= 1; k--)
        if (rem[(model_ptr + k) % N] > 0) w = (model_ptr + k) % N;
      rem[w]--;
      rep = reps - 1 - rem[w];
      d   = (fdelay != 0) ? fdelay : $urandom_range(6, 1);
      rs.delay = d;
      rs.data  = fdata_en ? fdata : $urandom;
      to = (d > TO);
      model_err = model_err | to;
      e.id = w; e.wen = pay_wen[w][rep]; e.addr = pay_addr[w][rep];
      e.num = pay_num[w][rep]; e.mode = pay_mode[w][rep]; e.dat_o = pay_dat[w][rep];
      e.dat_i = to ? '0 : rs.data;
      e.len   = to ? TO : d;
      e.gap   = first ? 0 : e.len + 2;
      e.err   = model_err;
      rsp_q.push_back(rs);
      exp_q.push_back(e);
      model_ptr = w;
      first = 1'b0;
    end
    @(posedge clk); #1;
    drive(mask, reps, dn);
    all_done = 1'b0;
    cyc = 0;
    while (!all_done && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) check("latency_cycle0_s_req", s_req, 0);
      if (cyc == 1) check("latency_cycle1_s_req", s_req, 1);
      for (int i = 0; i < N; i++) if (m_ready[i]) dn[i]++;
      all_done = 1'b1;
      for (int i = 0; i < N; i++) if (mask[i] && dn[i] < reps) all_done = 1'b0;
      @(posedge clk); #1;
      drive(mask, reps, dn);
      cyc++;
    end
    if (!all_done) check("round_completed", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic reset_mid_transfer();
    int unsigned cyc;
    fill_random();
    rsp_q.push_back('{delay: 50, data: '0});
    @(posedge clk); #1;
    m_req = 3'b010;
    m_wen = '0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!s_req && cyc < 10);
    check("reset_test_s_req_seen", s_req, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("reset_abort_s_req", s_req, 0);
    check("reset_abort_busy", busy, 0);
    check("reset_abort_m_ready", m_ready, 0);
    check("reset_abort_err", timeout_err, 0);
    check("reset_abort_grant", grant_id, 0);
    m_req = '0;
    repeat (2) @(negedge clk);
    rst       = 1'b1;
    model_ptr = N - 1;
    model_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_req = '0; m_wen = '0; m_addr = '0; m_num = '0; m_mode = '0; m_dat_o = '0;
    #2;
    check("reset_s_req", s_req, 0);
    check("reset_busy", busy, 0);
    check("reset_m_ready", m_ready, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_timeout_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    fill_random();
    run_round(3'b001, 1, TO, 1'b0, '0);

    fill_random();
    pay_wen[0][0]  = 1'b0;
    pay_addr[0][0] = AW'(32'h10);
    run_round(3'b001, 1, 3, 1'b1, 32'h1234_5678);

    fill_random();
    pay_wen[1][0] = 1'b1;
    pay_dat[1][0] = 32'hA5A5_A5A5;
    run_round(3'b010, 1, 0, 1'b0, '0);

    fill_random();
    run_round(3'b011, 2, 1, 1'b0, '0);

    fill_random();
    run_round(3'b001, 1, 10, 1'b0, '0);
    fill_random();
    run_round(3'b010, 1, 2, 1'b0, '0);

    for (int it = 0; it < 25; it++) begin
      fill_random();
      run_round(3'($urandom_range(7, 1)), $urandom_range(3, 1), 0, 1'b0, '0);
    end

    fill_random();
    run_round(3'b001, 1, 5, 1'b0, '0);
    reset_mid_transfer();
    fill_random();
    run_round(3'b011, 1, 1, 1'b0, '0);

    repeat (3) @(negedge clk);
    check("final_rsp_queue_empty", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
